// File: rtl/hazard_scoreboard_if.sv
// ID-stage interlock bus between the decode logic (master) and hazard_scoreboard (slave).
interface hazard_scoreboard_if #(
   parameter int NUM_REGS = 8,
   parameter int CNT_W    = 16
);
   localparam int REG_W = $clog2(NUM_REGS);

   logic             id_valid;
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic             id_src1_used;
   logic             id_src2_used;
   logic [REG_W-1:0] id_dest;
   logic             id_dest_we;
   logic             id_sets_cc;
   logic             id_reads_cc;
   logic             id_is_ctrl;
   logic             issue;
   logic             stall_id;
   logic             pc_load;
   logic             bubble_ex;
   logic             flush_if;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
             id_dest, id_dest_we, id_sets_cc, id_reads_cc, id_is_ctrl,
      input  issue, stall_id, pc_load, bubble_ex, flush_if, stall_count
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
             id_dest, id_dest_we, id_sets_cc, id_reads_cc, id_is_ctrl,
      output issue, stall_id, pc_load, bubble_ex, flush_if, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// LC-3b ID-stage interlock: shift-register scoreboard of in-flight instructions, RAW/CC/control stalls.
// Define HAZARD_WB_BYPASS_EN when the regfile is write-through so the WB slot is excluded from hazard checks.
module hazard_scoreboard #(
   parameter int NUM_REGS = 8,
   parameter int DEPTH    = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  bus
);
   localparam int REG_W = $clog2(NUM_REGS);
`ifdef HAZARD_WB_BYPASS_EN
   localparam int HZ_SLOTS = DEPTH - 1;
`else
   localparam int HZ_SLOTS = DEPTH;
`endif

   logic [DEPTH-1:0] r_v;
   logic [DEPTH-1:0] r_we;
   logic [DEPTH-1:0] r_cc;
   logic [DEPTH-1:0] r_ctrl;
   logic [REG_W-1:0] r_dest [DEPTH];
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_reg_hz;
   logic w_cc_hz;
   logic w_ctrl_busy;
   logic w_ctrl_retire;
   logic w_issue;
   logic w_stall_id;

   always_comb begin
      w_reg_hz    = 1'b0;
      w_cc_hz     = 1'b0;
      w_ctrl_busy = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_v[k] && r_ctrl[k])
            w_ctrl_busy = 1'b1;
         if (k < HZ_SLOTS && r_v[k]) begin
            if (r_we[k] && ((bus.id_src1_used && r_dest[k] == bus.id_src1) ||
                            (bus.id_src2_used && r_dest[k] == bus.id_src2)))
               w_reg_hz = 1'b1;
            if (bus.id_reads_cc && r_cc[k])
               w_cc_hz = 1'b1;
         end
      end
   end

   assign w_ctrl_retire = r_v[DEPTH-1] & r_ctrl[DEPTH-1];
   assign w_issue       = bus.id_valid & ~w_reg_hz & ~w_cc_hz & ~w_ctrl_busy;
   assign w_stall_id    = bus.id_valid & ~w_issue;

   assign bus.issue       = w_issue;
   assign bus.bubble_ex   = ~w_issue;
   assign bus.stall_id    = w_stall_id;
   // A retiring control transfer redirects the PC even while ID is stalled behind it.
   assign bus.pc_load     = ~w_stall_id | w_ctrl_retire;
   assign bus.flush_if    = w_ctrl_retire;
   assign bus.stall_count = r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v         <= '0;
         r_we        <= '0;
         r_cc        <= '0;
         r_ctrl      <= '0;
         r_stall_cnt <= '0;
         for (int k = 0; k < DEPTH; k++)
            r_dest[k] <= '0;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            r_v[k]    <= r_v[k-1];
            r_we[k]   <= r_we[k-1];
            r_cc[k]   <= r_cc[k-1];
            r_ctrl[k] <= r_ctrl[k-1];
            r_dest[k] <= r_dest[k-1];
         end
         r_v[0]    <= w_issue;
         r_we[0]   <= w_issue & bus.id_dest_we;
         r_cc[0]   <= w_issue & bus.id_sets_cc;
         r_ctrl[0] <= w_issue & bus.id_is_ctrl;
         r_dest[0] <= w_issue ? bus.id_dest : '0;
         if (w_stall_id && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: DEPTH=3 instance for hazards, DEPTH=5/CNT_W=4 instance for saturation.
module tb_hazard_scoreboard;
`ifdef HAZARD_WB_BYPASS_EN
   localparam int EXP_RAW = 3;
`else
   localparam int EXP_RAW = 4;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   hazard_scoreboard_if #(.NUM_REGS(8), .CNT_W(16)) m_if ();
   hazard_scoreboard_if #(.NUM_REGS(8), .CNT_W(4))  s_if ();

   hazard_scoreboard #(.NUM_REGS(8), .DEPTH(3), .CNT_W(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if)
   );

   hazard_scoreboard #(.NUM_REGS(8), .DEPTH(5), .CNT_W(4)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (s_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] d,
                        input logic we, input logic scc, input logic rcc, input logic ctrl);
      m_if.id_valid     = v;
      m_if.id_src1      = s1;
      m_if.id_src1_used = u1;
      m_if.id_src2      = s2;
      m_if.id_src2_used = u2;
      m_if.id_dest      = d;
      m_if.id_dest_we   = we;
      m_if.id_sets_cc   = scc;
      m_if.id_reads_cc  = rcc;
      m_if.id_is_ctrl   = ctrl;
      #2;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      s_if.id_valid = 0; s_if.id_src1 = 0; s_if.id_src2 = 0; s_if.id_src1_used = 0;
      s_if.id_src2_used = 0; s_if.id_dest = 0; s_if.id_dest_we = 0; s_if.id_sets_cc = 0;
      s_if.id_reads_cc = 0; s_if.id_is_ctrl = 0;
      do_reset();

      // reset state with id_valid=0
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_issue",  m_if.issue, 0);
      chk("rst_stall",  m_if.stall_id, 0);
      chk("rst_pcload", m_if.pc_load, 1);
      chk("rst_bubble", m_if.bubble_ex, 1);
      chk("rst_flush",  m_if.flush_if, 0);
      chk("rst_cnt",    m_if.stall_count, 0);

      // ADD R1,R2,R3 then ADD R2,R1,R3
      drive(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
      chk("raw_prod_issue", m_if.issue, 1);
      tick();
      for (int c = 1; c <= 4; c++) begin
         drive(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
         chk($sformatf("raw_issue_c%0d", c), m_if.issue, (c >= EXP_RAW) ? 1 : 0);
         if (c == 1) begin
            chk("raw_pcload", m_if.pc_load, 0);
            chk("raw_bubble", m_if.bubble_ex, 1);
         end
         if (c == 4) chk("raw_cnt", m_if.stall_count, EXP_RAW - 1);
         tick();
      end

      // immediate form: R1 in unused src2 field must not stall; used src2 must
      do_reset();
      drive(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
      tick();
      drive(1, 3, 1, 1, 0, 2, 1, 0, 0, 0);
      chk("imm_no_stall", m_if.issue, 1);
      tick();
      drive(1, 5, 1, 1, 1, 4, 1, 0, 0, 0);
      chk("src2_hz", m_if.stall_id, 1);

      // R7 link destination
      do_reset();
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      tick();
      drive(1, 7, 1, 0, 0, 3, 1, 0, 0, 0);
      chk("r7_hz", m_if.stall_id, 1);

      // LDR setting CC, then a CC reader
      do_reset();
      drive(1, 2, 1, 0, 0, 4, 1, 1, 0, 0);
      tick();
      for (int c = 1; c <= 4; c++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         chk($sformatf("cc_issue_c%0d", c), m_if.issue, (c >= EXP_RAW) ? 1 : 0);
         tick();
      end

      // control transfer issued at t
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("br_issue", m_if.issue, 1);
      tick();
      drive(1, 6, 1, 6, 1, 5, 1, 0, 0, 0);
      chk("br_stall1", m_if.stall_id, 1);
      chk("br_flush1", m_if.flush_if, 0);
      tick();
      drive(1, 6, 1, 6, 1, 5, 1, 0, 0, 0);
      chk("br_stall2",  m_if.stall_id, 1);
      chk("br_pcload2", m_if.pc_load, 0);
      tick();
      drive(1, 6, 1, 6, 1, 5, 1, 0, 0, 0);
      chk("br_flush3",  m_if.flush_if, 1);
      chk("br_pcload3", m_if.pc_load, 1);
      chk("br_issue3",  m_if.issue, 0);
      tick();
      drive(1, 6, 1, 6, 1, 5, 1, 0, 0, 0);
      chk("br_issue4", m_if.issue, 1);
      chk("br_flush4", m_if.flush_if, 0);

      // reset asserted mid-stall with producers in flight
      do_reset();
      drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      tick();
      drive(1, 3, 1, 0, 0, 4, 1, 0, 1, 0);
      chk("pre_rst_stall", m_if.stall_id, 1);
      tick();
      drive(1, 3, 1, 0, 0, 4, 1, 0, 1, 0);
      chk("pre_rst_cnt", m_if.stall_count, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_issue", m_if.issue, 1);
      chk("async_rst_cnt",   m_if.stall_count, 0);
      #2;
      rst = 1'b0;
      tick();
      drive(1, 5, 1, 6, 1, 2, 1, 0, 0, 0);
      chk("post_rst_issue", m_if.issue, 1);
      chk("post_rst_cnt",   m_if.stall_count, 0);

      // saturation on the DEPTH=5, CNT_W=4 instance: back-to-back control instructions
      do_reset();
      s_if.id_valid   = 1'b1;
      s_if.id_is_ctrl = 1'b1;
      #2;
      for (int cyc = 0; cyc <= 30; cyc++) begin
         if (cyc == 6) begin
            chk("sat_cnt6",   s_if.stall_count, 5);
            chk("sat_issue6", s_if.issue, 1);
         end
         if (cyc == 17) chk("sat_cnt17", s_if.stall_count, 14);
         if (cyc == 18) chk("sat_cnt18", s_if.stall_count, 15);
         if (cyc == 30) chk("sat_cnt30", s_if.stall_count, 15);
         tick();
         #2;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
